cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit dataflow carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into SEGS pipeline segments. Each segment is a GROUP-wise carry-lookahead adder. The carry between segments is registered.
- Valid/ready handshake on both sides. Sits in datapaths that need full-width add/sub at one result per clock without a long carry chain.

Parameters:
- WIDTH, 32: operand/result width in bits.
- SEGS, 4: number of pipeline segments; must divide WIDTH. This is also the latency in cycles.
- GROUP, 4: CLA group width inside a segment; must divide WIDTH/SEGS. Generate/propagate are computed per group, with lookahead across groups.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: block can accept a beat this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in (add mode) or borrow-in (sub mode).
- sub, input, 1: 0 = add, 1 = subtract.
- out_valid, output, 1: result beat valid.
- out_ready, input, 1: downstream accepts the result.
- sum, output, WIDTH: result.
- cout, output, 1: carry out of the MSB. In sub mode, 1 means no borrow.
- ovf, output, 1: two's-complement overflow, equal to carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: while rst_n is low at a clock edge, all stage valid bits, sum, cout, ovf and out_valid are cleared to 0 and all data registers are cleared to 0. in_ready is driven 0 whenever rst_n is low.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted for them.
- Arithmetic:
  - b_eff = b XOR {WIDTH{sub}}.
  - c0 = cin XOR sub.
  - sum = a + b_eff + c0, modulo 2^WIDTH.
  - With sub=1: cin=0 gives a−b; cin=1 gives a−b−1.
  - The result must equal the full-width sum for all inputs and all legal parameter combinations.
- Per-segment carry-lookahead, for segment bits i:
  - p = a^b_eff, g = a&b_eff.
  - c[i+1] = g[i] | p[i]&c[i], expanded per GROUP.
  - sum[i] = p[i]^c[i].
- Pipeline:
  - Stage k register (k = 0..SEGS−1) holds: valid bit; finished sum bits of segments 0..k; carry out of segment k; raw a/b_eff bits of segments k+1..SEGS−1.
  - Stage 0 computes segment 0 from c0 when a beat is accepted.
  - Stage k computes segment k from the stage k−1 registered carry.
  - The last stage also produces ovf.
  - sum, cout, ovf and out_valid are driven directly from the last stage register, with no combinational path from a/b.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance (when rst_n is high).
  - A beat is accepted when in_valid & in_ready.
  - When advance is 1, every stage loads from its predecessor; stage 0 loads the accepted beat, or a bubble (valid=0) if none.
  - When advance is 0, all stages hold.
- Latency and throughput:
  - Latency is exactly SEGS cycles from accept edge to out_valid, absent stalls.
  - Throughput is 1 beat per cycle with out_ready held high.
  - Beats are never dropped, duplicated or reordered.
- Stall: while out_valid=1 and out_ready=0, sum, cout and ovf are held stable.
- Simultaneous consume and accept: in the same cycle, the output is consumed and a new beat enters stage 0; no bubble is inserted.
- Degenerate parameters:
  - SEGS=1: single-stage registered CLA, latency 1.
  - GROUP=WIDTH/SEGS: one lookahead group per segment.

Test Plan (WIDTH=32, SEGS=4, GROUP=4 unless stated):
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=0. After release, in_ready=1.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0. out_valid rises exactly 4 cycles after accept.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Same operands with cin=1 -> sum=0xFFFFFFFD.
- Overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, cout=0. a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Streaming: 8 back-to-back random beats with out_ready toggling 1,0,1,0 -> all 8 results match the reference model in order. in_ready=0 exactly in the stalled cycles, and outputs are stable while stalled.
- Reset in flight, plus parameter sweep:
  - Reset in flight: 3 beats in flight, pulse rst_n=0 for 1 cycle -> out_valid=0 next cycle; no stale results emitted afterwards.
  - Sweep: rerun the random test with (WIDTH,SEGS,GROUP) = (8,1,4), (16,2,2) and (64,8,8), checking latency = SEGS.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: SEGS carry-lookahead segments, one per stage,
// with a registered carry between segments and a valid/ready handshake on both sides.

module cla_seg #(
    parameter int W     = 8,
    parameter int GROUP = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic [W-1:0] o_s,
    output logic         o_c
);
    localparam int NG = W / GROUP;

    logic [W-1:0] w_p, w_g;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Group generate/propagate first, then group carries look ahead across groups;
    // bit carries inside a group expand from that group's carry-in.
    always_comb begin
        logic gc, gg, gp, bc;
        o_s = '0;
        gc  = i_c;
        gg  = 1'b0;
        gp  = 1'b0;
        bc  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                gg = w_g[j*GROUP+k] | (w_p[j*GROUP+k] & gg);
                gp = gp & w_p[j*GROUP+k];
            end
            bc = gc;
            for (int k = 0; k < GROUP; k++) begin
                o_s[j*GROUP+k] = w_p[j*GROUP+k] ^ bc;
                bc = w_g[j*GROUP+k] | (w_p[j*GROUP+k] & bc);
            end
            gc = gg | (gp & gc);
        end
        o_c = gc;
    end
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4,
    parameter int GROUP = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int SW = WIDTH / SEGS;

    logic             w_adv, w_acc;
    logic [WIDTH-1:0] w_beff;
    logic [SEGS-1:0]  r_vld;

    assign w_adv      = !r_vld[SEGS-1] || i_out_ready;
    assign o_in_ready = i_rst_n && w_adv;
    assign w_acc      = i_in_valid && o_in_ready;
    assign w_beff     = i_b ^ {WIDTH{i_sub}};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)   r_vld <= '0;
        else if (w_adv) r_vld <= SEGS'({r_vld, w_acc});
    end

    for (genvar k = 0; k < SEGS; k++) begin : g_stg
        localparam int LO = k * SW;

        // r_s: finished sum bits below the next segment, raw a bits above.
        logic [WIDTH-1:0] w_word, w_nxt, r_s;
        logic [SW-1:0]    w_bseg, w_sseg;
        logic             w_cin, w_cout, r_c;

        if (k == 0) begin : g_src
            assign w_word = i_a;
            assign w_bseg = w_beff[SW-1:0];
            assign w_cin  = i_cin ^ i_sub;
        end else begin : g_src
            assign w_word = g_stg[k-1].r_s;
            assign w_bseg = g_stg[k-1].g_bh.r_bh[SW-1:0];
            assign w_cin  = g_stg[k-1].r_c;
        end

        cla_seg #(.W(SW), .GROUP(GROUP)) u_seg (
            .i_a (w_word[LO +: SW]),
            .i_b (w_bseg),
            .i_c (w_cin),
            .o_s (w_sseg),
            .o_c (w_cout)
        );

        always_comb begin
            w_nxt           = w_word;
            w_nxt[LO +: SW] = w_sseg;
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_s <= w_nxt;
                r_c <= w_cout;
            end
        end

        // Only the not-yet-consumed b_eff bits travel down the pipe.
        if (k < SEGS-1) begin : g_bh
            logic [WIDTH-LO-SW-1:0] r_bh, w_bhi;
            if (k == 0) begin : g_bsrc
                assign w_bhi = w_beff[WIDTH-1:SW];
            end else begin : g_bsrc
                assign w_bhi = g_stg[k-1].g_bh.r_bh[WIDTH-LO-1:SW];
            end
            always_ff @(posedge i_clk) begin
                if (!i_rst_n)   r_bh <= '0;
                else if (w_adv) r_bh <= w_bhi;
            end
        end

        // Carry into the MSB is recovered from the MSB sum bit: s = p ^ c.
        if (k == SEGS-1) begin : g_ovf
            logic w_cmsb, r_ovf;
            assign w_cmsb = w_sseg[SW-1] ^ w_word[WIDTH-1] ^ w_bseg[SW-1];
            always_ff @(posedge i_clk) begin
                if (!i_rst_n)   r_ovf <= 1'b0;
                else if (w_adv) r_ovf <= w_cmsb ^ w_cout;
            end
        end
    end

    assign o_out_valid = r_vld[SEGS-1];
    assign o_sum       = g_stg[SEGS-1].r_s;
    assign o_cout      = g_stg[SEGS-1].r_c;
    assign o_ovf       = g_stg[SEGS-1].g_ovf.r_ovf;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: four parameterisations driven in lockstep, each checked
// every cycle against a plain-arithmetic model with a per-instance expected-beat FIFO.

module tb_cla_pipe_adder;
    localparam int WD [4] = '{32, 8, 16, 64};
    localparam int SG [4] = '{4, 1, 2, 8};

    logic        clk = 1'b0;
    logic        rst_n, in_valid, cin, sub, out_ready;
    logic [63:0] a, b;
    logic [3:0]  in_rdy, out_vld, co, ov;
    logic [63:0] s [4];
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [15:0] s2;
    logic [63:0] s3;

    assign s[0] = 64'(s0);
    assign s[1] = 64'(s1);
    assign s[2] = 64'(s2);
    assign s[3] = s3;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .SEGS(4), .GROUP(4)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_rdy[0]),
        .i_a(a[31:0]), .i_b(b[31:0]), .i_cin(cin), .i_sub(sub), .o_out_valid(out_vld[0]),
        .i_out_ready(out_ready), .o_sum(s0), .o_cout(co[0]), .o_ovf(ov[0]));
    cla_pipe_adder #(.WIDTH(8), .SEGS(1), .GROUP(4)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_rdy[1]),
        .i_a(a[7:0]), .i_b(b[7:0]), .i_cin(cin), .i_sub(sub), .o_out_valid(out_vld[1]),
        .i_out_ready(out_ready), .o_sum(s1), .o_cout(co[1]), .o_ovf(ov[1]));
    cla_pipe_adder #(.WIDTH(16), .SEGS(2), .GROUP(2)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_rdy[2]),
        .i_a(a[15:0]), .i_b(b[15:0]), .i_cin(cin), .i_sub(sub), .o_out_valid(out_vld[2]),
        .i_out_ready(out_ready), .o_sum(s2), .o_cout(co[2]), .o_ovf(ov[2]));
    cla_pipe_adder #(.WIDTH(64), .SEGS(8), .GROUP(8)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_rdy[3]),
        .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub), .o_out_valid(out_vld[3]),
        .i_out_ready(out_ready), .o_sum(s3), .o_cout(co[3]), .o_ovf(ov[3]));

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic        su;
        int          cyc;
    } beat_t;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    beat_t       mem [4][256];
    int          wr [4], rd [4], pops [4], last_stall [4];
    logic        stall_prev [4];
    logic [63:0] hs [4];
    logic        hc [4], hv [4];
    logic        prev_rst_low = 1'b0;

    // Reference: wide integer add, overflow from operand/result signs.
    function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, input logic su, output logic [63:0] rs,
                                  output logic rc, output logic rv);
        logic [64:0] full;
        logic [63:0] m, xa, be;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        xa   = x & m;
        be   = (su ? ~y : y) & m;
        full = {1'b0, xa} + {1'b0, be} + 65'(ci ^ su);
        rs   = full[63:0] & m;
        rc   = full[w];
        rv   = (xa[w-1] == be[w-1]) && (rs[w-1] != xa[w-1]);
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d actual=%h expected=%h", nm, d, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t       hd;
        logic [63:0] es;
        logic        ec, ev, vld;
        cyc++;
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
                chk("rst_in_ready", d, 64'(in_rdy[d]), 64'd0);
                rd[d] = wr[d];
                stall_prev[d] = 1'b0;
            end else begin
                vld = out_vld[d];
                if (prev_rst_low)
                    chk("rst_state", d, {s[d][60:0], vld, co[d], ov[d]}, 64'd0);
                chk("in_ready", d, 64'(in_rdy[d]), 64'(!vld || out_ready));
                if (vld) begin
                    if (rd[d] == wr[d]) begin
                        chk("spurious_out", d, 64'd1, 64'd0);
                    end else begin
                        hd = mem[d][rd[d] % 256];
                        model(WD[d], hd.a, hd.b, hd.ci, hd.su, es, ec, ev);
                        chk("sum", d, s[d], es);
                        chk("cout", d, 64'(co[d]), 64'(ec));
                        chk("ovf", d, 64'(ov[d]), 64'(ev));
                        if (stall_prev[d])
                            chk("stall_hold", d, {s[d][61:0], co[d], ov[d]}, {hs[d][61:0], hc[d], hv[d]});
                        if (out_ready) begin
                            if (last_stall[d] < hd.cyc)
                                chk("latency", d, 64'(cyc - hd.cyc), 64'(SG[d]));
                            rd[d]++;
                            pops[d]++;
                        end
                    end
                end
                stall_prev[d] = vld && !out_ready;
                hs[d] = s[d];
                hc[d] = co[d];
                hv[d] = ov[d];
                if (stall_prev[d]) last_stall[d] = cyc;
                if (in_valid && in_rdy[d]) begin
                    mem[d][wr[d] % 256] = '{a: a, b: b, ci: cin, su: sub, cyc: cyc};
                    wr[d]++;
                end
            end
        end
        prev_rst_low = !rst_n;
    end

    task automatic send_dir(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                            input logic ci, input logic su, input logic [31:0] es,
                            input logic ec, input logic ev);
        int n;
        n = 0;
        out_ready = 1'b1;
        a = {32'h0, xa};
        b = {32'h0, xb};
        cin = ci;
        sub = su;
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n++;
            if (out_vld[0]) break;
        end
        chk({nm, "_lat"}, 0, 64'(n), 64'd4);
        chk({nm, "_sum"}, 0, s[0], 64'(es));
        chk({nm, "_cout"}, 0, 64'(co[0]), 64'(ec));
        chk({nm, "_ovf"}, 0, 64'(ov[0]), 64'(ev));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ms;
        logic        mc, mv, tog, have, took, seen;
        int          beats, p0;

        for (int d = 0; d < 4; d++) begin
            wr[d] = 0; rd[d] = 0; pops[d] = 0; last_stall[d] = -1; stall_prev[d] = 1'b0;
        end
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0;

        // Reset with in_valid asserted.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 0, {s[0][60:0], out_vld[0], co[0], ov[0]}, 64'd0);
        chk("reset_in_ready", 0, 64'(in_rdy[0]), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("release_in_ready", 0, 64'(in_rdy[0]), 64'd1);

        // Pin the model on hand-computed values.
        model(32, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, ms, mc, mv);
        chk("model_ripple", 0, {ms[61:0], mc, mv}, {62'h0, 1'b1, 1'b0});
        model(32, 64'h8000_0000, 64'h1, 1'b0, 1'b1, ms, mc, mv);
        chk("model_ovf_sub", 0, {ms[61:0], mc, mv}, {62'h7FFF_FFFF, 1'b1, 1'b1});
        model(8, 64'h7F, 64'h1, 1'b0, 1'b0, ms, mc, mv);
        chk("model_ovf8", 1, {ms[61:0], mc, mv}, {62'h80, 1'b0, 1'b1});

        send_dir("ripple",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_dir("sub57",   32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_dir("sub57c",  32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        send_dir("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_dir("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Streaming with out_ready toggling 1,0,1,0.
        p0 = pops[0]; tog = 1'b1; have = 1'b0; beats = 0;
        for (int t = 0; t < 100 && beats < 8; t++) begin
            out_ready = tog;
            tog = !tog;
            if (!have) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                cin = 1'($urandom); sub = 1'($urandom); have = 1'b1;
            end
            in_valid = 1'b1;
            #1;
            took = in_rdy[0];
            @(posedge clk);
            #1;
            if (took) begin beats++; have = 1'b0; end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_accepted", 0, 64'(beats), 64'd8);
        repeat (20) @(posedge clk);
        #1;
        chk("stream_emitted", 0, 64'(pops[0] - p0), 64'd8);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_flight_valid", 0, 64'(out_vld[0]), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_vld[0];
        end
        chk("no_stale", 0, 64'(seen), 64'd0);

        // Random traffic on every instance, then a full-rate run for latency.
        for (int t = 0; t < 300; t++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("drained", d, 64'(wr[d] - rd[d]), 64'd0);
            chk("throughput", d, 64'(pops[d] > 100), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
